// File: rtl/vga_sync_generator.sv
// -----------------------------------------------------------------------------
// vga_sync_generator
//
// Turns the raw horizontal/vertical counts of the 640x480@60 Hz display path
// into registered VGA sync pulses, a display-enable window, visible-area pixel
// coordinates, line/frame strobes, a frame counter and an out-of-range strobe.
// Every output leaves the same two-stage pipeline, so all outputs for one
// (H,V) input pair appear together, two clock edges after it was sampled.
//
// Ports:
//   clk_25MHz      in   pixel clock, single clock domain
//   rst_n          in   asynchronous active-low reset
//   H_count_Value  in   [15:0] horizontal count
//   V_count_Value  in   [15:0] vertical count
//   hsync          out  horizontal sync, active level SYNC_POL
//   vsync          out  vertical sync, active level SYNC_POL
//   video_on       out  high inside the visible area
//   pixel_x        out  [9:0] visible column, 0 outside the visible area
//   pixel_y        out  [9:0] visible row, 0 outside the visible area
//   line_start     out  pulse for H == 0 with an in-range V
//   frame_start    out  pulse for H == 0 and V == 0
//   frame_count    out  [15:0] frame_start pulses since reset, wrapping
//   range_err      out  pulse for each cycle with an out-of-range input
// -----------------------------------------------------------------------------
module vga_sync_generator #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic        clk_25MHz,
    input  logic        rst_n,
    input  logic [15:0] H_count_Value,
    input  logic [15:0] V_count_Value,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        range_err
);

    // Window boundaries, all held at the full 16-bit input width so the
    // compares are plain unsigned 16-bit compares.
    localparam logic [15:0] H_VIS_END    = 16'(H_VISIBLE);
    localparam logic [15:0] H_SYNC_START = 16'(H_VISIBLE + H_FP);
    localparam logic [15:0] H_SYNC_END   = 16'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [15:0] H_TOTAL      = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP);
    localparam logic [15:0] V_VIS_END    = 16'(V_VISIBLE);
    localparam logic [15:0] V_SYNC_START = 16'(V_VISIBLE + V_FP);
    localparam logic [15:0] V_SYNC_END   = 16'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [15:0] V_TOTAL      = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP);

    // Drive level of a sync output given whether the pulse is active.
    function automatic logic sync_level(input logic active);
        return active ? SYNC_POL : ~SYNC_POL;
    endfunction

    logic in_range;

    logic       h_vis_p1;
    logic       v_vis_p1;
    logic       h_sync_p1;
    logic       v_sync_p1;
    logic       h_zero_p1;
    logic       v_zero_p1;
    // Stored as "out of range" so that the cleared reset state means
    // "no error"; the first cycles after release then look like reset.
    logic       oor_p1;
    logic [9:0] h_low_p1;
    logic [9:0] v_low_p1;

    logic       vis_p1;
    logic       frame_hit_p1;

    assign in_range = (H_count_Value < H_TOTAL) && (V_count_Value < V_TOTAL);

    // ---- stage 1: compare flags and low count bits ----
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_vis_p1  <= 1'b0;
            v_vis_p1  <= 1'b0;
            h_sync_p1 <= 1'b0;
            v_sync_p1 <= 1'b0;
            h_zero_p1 <= 1'b0;
            v_zero_p1 <= 1'b0;
            oor_p1    <= 1'b0;
            h_low_p1  <= 10'd0;
            v_low_p1  <= 10'd0;
        end else begin
            h_vis_p1  <= (H_count_Value < H_VIS_END);
            v_vis_p1  <= (V_count_Value < V_VIS_END);
            h_sync_p1 <= (H_count_Value >= H_SYNC_START) && (H_count_Value < H_SYNC_END);
            v_sync_p1 <= (V_count_Value >= V_SYNC_START) && (V_count_Value < V_SYNC_END);
            h_zero_p1 <= (H_count_Value == 16'd0);
            v_zero_p1 <= (V_count_Value == 16'd0);
            oor_p1    <= ~in_range;
            h_low_p1  <= H_count_Value[9:0];
            v_low_p1  <= V_count_Value[9:0];
        end
    end

    assign vis_p1       = h_vis_p1 & v_vis_p1 & ~oor_p1;
    // (0,0) is always in range, so no range qualification is needed here.
    assign frame_hit_p1 = h_zero_p1 & v_zero_p1;

    // ---- stage 2: registered outputs ----
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
            range_err   <= 1'b0;
        end else begin
            hsync       <= sync_level(h_sync_p1 & ~oor_p1);
            vsync       <= sync_level(v_sync_p1 & ~oor_p1);
            video_on    <= vis_p1;
            pixel_x     <= vis_p1 ? h_low_p1 : 10'd0;
            pixel_y     <= vis_p1 ? v_low_p1 : 10'd0;
            line_start  <= h_zero_p1 & ~oor_p1;
            frame_start <= frame_hit_p1;
            range_err   <= oor_p1;
            // Counts in the same edge that registers frame_start; wraps naturally.
            if (frame_hit_p1) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule
